// File: rtl/jesd_tx_sync.sv
// JESD204B transmit link-layer synchronization for a single lane.
// Runs CGS (/K/ fill), a multi-multiframe ILAS locked to the LMFC, then user
// data pass-through. Also watches SYNC~ for error reports and resync requests.
module jesd_tx_sync #(
  parameter int PARALLEL_OCTETS       = 4,
  parameter int OCTETS_PER_MULTIFRAME = 32,
  parameter int ILAS_MULTIFRAMES      = 4,
  parameter int SYNC_RESYNC_BEATS     = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sync_ni,
  input  logic                         lmfc_edge_i,
  input  logic [111:0]                 cfg_i,
  input  logic [8*PARALLEL_OCTETS-1:0] data_i,
  output logic                         data_ready_o,
  output logic [8*PARALLEL_OCTETS-1:0] tx_data_o,
  output logic [PARALLEL_OCTETS-1:0]   tx_charisk_o,
  output logic                         link_up_o,
  output logic [7:0]                   sync_err_cnt_o
);

  localparam int P      = PARALLEL_OCTETS;
  localparam int B      = OCTETS_PER_MULTIFRAME / PARALLEL_OCTETS;
  localparam int BEAT_W = (B > 1) ? $clog2(B) : 1;
  localparam int MF_W   = $clog2(ILAS_MULTIFRAMES);
  localparam int LOW_W  = $clog2(SYNC_RESYNC_BEATS + 1);

  localparam logic [7:0] K28_0 = 8'h1C;  // start of multiframe
  localparam logic [7:0] K28_3 = 8'h7C;  // end of multiframe
  localparam logic [7:0] K28_4 = 8'h9C;  // start of configuration data
  localparam logic [7:0] K28_5 = 8'hBC;  // code-group sync

  typedef enum logic [1:0] {
    ST_CGS       = 2'd0,
    ST_WAIT_LMFC = 2'd1,
    ST_ILAS      = 2'd2,
    ST_DATA      = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next;
  logic [MF_W-1:0]     mf_reg, mf_next;
  logic [LOW_W-1:0]    low_reg, low_next;
  logic [7:0]          err_reg, err_next;
  logic [8*P-1:0]      tx_data_reg, tx_data_next;
  logic [P-1:0]        charisk_reg, charisk_next;
  logic                link_up_reg, link_up_next;

  // ILAS position actually being generated; zero outside ILAS so the
  // WAIT_LMFC load naturally produces multiframe 0, beat 0.
  logic [BEAT_W-1:0]   sel_beat;
  logic [MF_W-1:0]     sel_mf;
  logic [BEAT_W-1:0]   adv_beat;
  logic [MF_W-1:0]     adv_mf;
  logic                beat_last;
  logic                ilas_last;
  logic [LOW_W-1:0]    low_inc;
  logic [127:0]        cfg_pad;
  logic [8*P-1:0]      ilas_data;
  logic [P-1:0]        ilas_k;

  assign sel_beat  = (state_reg == ST_ILAS) ? beat_reg : '0;
  assign sel_mf    = (state_reg == ST_ILAS) ? mf_reg : '0;
  assign beat_last = (sel_beat == BEAT_W'(B - 1));
  assign adv_beat  = beat_last ? '0 : sel_beat + BEAT_W'(1);
  assign adv_mf    = beat_last ? sel_mf + MF_W'(1) : sel_mf;
  assign ilas_last = beat_last && (sel_mf == MF_W'(ILAS_MULTIFRAMES - 1));
  assign low_inc   = low_reg + LOW_W'(1);
  // Pad the 14 config octets to 16 so a 4-bit octet select never runs off the end.
  assign cfg_pad   = {16'h0000, cfg_i};

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_lane
      logic [15:0] oct_idx;
      logic [3:0]  cfg_sel;
      logic [7:0]  oct;
      logic        oct_k;

      assign oct_idx = 16'(sel_beat) * 16'(P) + 16'(gi);
      assign cfg_sel = 4'(oct_idx - 16'd2);

      // ILAS octet for this lane: frame markers, config block in multiframe 1, ramp elsewhere.
      always_comb begin
        oct_k = 1'b0;
        oct   = oct_idx[7:0];
        if (oct_idx == 16'd0) begin
          oct_k = 1'b1;
          oct   = K28_0;
        end else if (oct_idx == 16'(OCTETS_PER_MULTIFRAME - 1)) begin
          oct_k = 1'b1;
          oct   = K28_3;
        end else if (sel_mf == MF_W'(1)) begin
          if (oct_idx == 16'd1) begin
            oct_k = 1'b1;
            oct   = K28_4;
          end else if (oct_idx <= 16'd15) begin
            oct = cfg_pad[{cfg_sel, 3'b000} +: 8];
          end
        end
      end

      assign ilas_data[8*gi +: 8] = oct;
      assign ilas_k[gi]           = oct_k;
    end
  endgenerate

  // Next-state, next-output and SYNC~ monitor logic.
  always_comb begin
    state_next   = state_reg;
    beat_next    = '0;
    mf_next      = '0;
    low_next     = '0;
    err_next     = err_reg;
    tx_data_next = {P{K28_5}};
    charisk_next = '1;
    link_up_next = 1'b0;

    case (state_reg)
      ST_CGS: begin
        if (sync_ni) state_next = ST_WAIT_LMFC;
      end
      ST_WAIT_LMFC: begin
        if (!sync_ni) begin
          state_next = ST_CGS;
        end else if (lmfc_edge_i) begin
          state_next   = ST_ILAS;
          tx_data_next = ilas_data;
          charisk_next = ilas_k;
          beat_next    = adv_beat;
          mf_next      = adv_mf;
        end
      end
      ST_ILAS: begin
        tx_data_next = ilas_data;
        charisk_next = ilas_k;
        beat_next    = adv_beat;
        mf_next      = adv_mf;
        if (ilas_last) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx_data_next = data_i;
        charisk_next = '0;
        link_up_next = 1'b1;
      end
      default: state_next = ST_CGS;
    endcase

    // A resync request overrides the ILAS->DATA step taken above.
    if (state_reg == ST_ILAS || state_reg == ST_DATA) begin
      if (!sync_ni) begin
        if (low_inc == LOW_W'(SYNC_RESYNC_BEATS)) begin
          state_next = ST_CGS;
        end else begin
          low_next = low_inc;
        end
      end else if (low_reg != '0) begin
        if (err_reg != 8'hFF) err_next = err_reg + 8'd1;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_CGS;
      beat_reg    <= '0;
      mf_reg      <= '0;
      low_reg     <= '0;
      err_reg     <= '0;
      tx_data_reg <= {P{K28_5}};
      charisk_reg <= '1;
      link_up_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      mf_reg      <= mf_next;
      low_reg     <= low_next;
      err_reg     <= err_next;
      tx_data_reg <= tx_data_next;
      charisk_reg <= charisk_next;
      link_up_reg <= link_up_next;
    end
  end

  assign data_ready_o   = (state_reg == ST_DATA);
  assign tx_data_o      = tx_data_reg;
  assign tx_charisk_o   = charisk_reg;
  assign link_up_o      = link_up_reg;
  assign sync_err_cnt_o = err_reg;

endmodule
